// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC sample packer.
package adc_pkg;

  typedef logic [11:0] adc_sample_t;

  typedef enum logic [1:0] {
    PH_A,
    PH_B,
    PH_C,
    PH_P
  } pack_phase_e;

  localparam int LOWRES_MSB = 11;

endpackage

// File: rtl/adc_packer_stats.sv
// Saturating byte and underflow counters for the ADC sample packer.
module adc_packer_stats #(
  parameter int pCNT_BITS = 32
) (
  input  logic                 clk_usb,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 byte_inc,
  input  logic                 uflow_inc,
  output logic [pCNT_BITS-1:0] stat_bytes,
  output logic [pCNT_BITS-1:0] stat_underflows
);

  logic [pCNT_BITS-1:0] bytes_q, bytes_d;
  logic [pCNT_BITS-1:0] uflow_q, uflow_d;

  always_comb begin
    bytes_d = bytes_q;
    uflow_d = uflow_q;
    if (byte_inc && (bytes_q != '1)) bytes_d = bytes_q + 1'b1;
    if (uflow_inc && (uflow_q != '1)) uflow_d = uflow_q + 1'b1;
  end

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      bytes_q <= '0;
      uflow_q <= '0;
    end else if (clear) begin
      bytes_q <= '0;
      uflow_q <= '0;
    end else begin
      bytes_q <= bytes_d;
      uflow_q <= uflow_d;
    end
  end

  assign stat_bytes      = bytes_q;
  assign stat_underflows = uflow_q;

endmodule

// File: rtl/adc_sample_packer.sv
// Packs 12-bit ADC samples into a byte stream (3 bytes per pair, or 1 byte per sample in low-res mode).
// Define ADC_PACKER_STATS_EN to enable the saturating stat_bytes / stat_underflows counters.
module adc_sample_packer
  import adc_pkg::*;
#(
  parameter int pSAMPLE_BITS = 12,
  parameter int pCNT_BITS    = 32
) (
  input  logic                    clk_usb,
  input  logic                    reset_n,
  input  logic                    cfg_low_res,
  input  logic                    clear,
  input  logic [pSAMPLE_BITS-1:0] in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [7:0]              out_byte,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    underflow,
  output logic [pCNT_BITS-1:0]    stat_bytes,
  output logic [pCNT_BITS-1:0]    stat_underflows
);

  generate
    if (pSAMPLE_BITS != 12) begin : g_bad_width
      $error("adc_sample_packer: pSAMPLE_BITS must be 12");
    end
  endgenerate

  pack_phase_e phase_q, phase_d;
  logic [7:0]  residue_q, residue_d;
  logic [7:0]  out_byte_q, out_byte_d;
  logic        out_valid_q, out_valid_d;
  logic        underflow_q, underflow_d;
  logic        out_free;
  adc_sample_t sample;

  assign sample   = in_data;
  assign out_free = !out_valid_q || out_ready;
  assign in_ready = out_free && ((phase_q == PH_A) || (phase_q == PH_B));

  // A free slot with nothing to load drops out_valid but keeps the last byte visible.
  always_comb begin
    phase_d     = phase_q;
    residue_d   = residue_q;
    out_byte_d  = out_byte_q;
    out_valid_d = out_valid_q;
    underflow_d = out_ready && !out_valid_q;
    if (out_free) begin
      out_valid_d = 1'b0;
      unique case (phase_q)
        PH_A: begin
          if (in_valid) begin
            out_byte_d  = sample[LOWRES_MSB -: 8];
            out_valid_d = 1'b1;
            if (!cfg_low_res) begin
              residue_d = {4'h0, sample[3:0]};
              phase_d   = in_last ? PH_P : PH_B;
            end
          end
        end
        PH_B: begin
          if (in_valid) begin
            out_byte_d  = {residue_q[3:0], sample[11:8]};
            out_valid_d = 1'b1;
            residue_d   = sample[7:0];
            phase_d     = PH_C;
          end
        end
        PH_C: begin
          out_byte_d  = residue_q;
          out_valid_d = 1'b1;
          phase_d     = PH_A;
        end
        PH_P: begin
          out_byte_d  = {residue_q[3:0], 4'h0};
          out_valid_d = 1'b1;
          phase_d     = PH_A;
        end
      endcase
    end
  end

  always_ff @(posedge clk_usb or negedge reset_n) begin
    if (!reset_n) begin
      phase_q     <= PH_A;
      residue_q   <= '0;
      out_byte_q  <= '0;
      out_valid_q <= 1'b0;
      underflow_q <= 1'b0;
    end else if (clear) begin
      phase_q     <= PH_A;
      residue_q   <= '0;
      out_byte_q  <= '0;
      out_valid_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      residue_q   <= residue_d;
      out_byte_q  <= out_byte_d;
      out_valid_q <= out_valid_d;
      underflow_q <= underflow_d;
    end
  end

  assign out_byte  = out_byte_q;
  assign out_valid = out_valid_q;
  assign underflow = underflow_q;

`ifdef ADC_PACKER_STATS_EN
  adc_packer_stats #(
    .pCNT_BITS (pCNT_BITS)
  ) u_stats (
    .clk_usb         (clk_usb),
    .reset_n         (reset_n),
    .clear           (clear),
    .byte_inc        (out_valid_q && out_ready),
    .uflow_inc       (underflow_d),
    .stat_bytes      (stat_bytes),
    .stat_underflows (stat_underflows)
  );
`else
  assign stat_bytes      = '0;
  assign stat_underflows = '0;
`endif

endmodule

// File: tb/tb_adc_sample_packer.sv
// Scoreboard bench for adc_sample_packer: directed byte streams, stalls, underflow, clear/reset mid-pair.
module tb_adc_sample_packer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_low_res = 1'b0;
  logic        clear = 1'b0;
  logic [11:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        underflow;
  logic [31:0] stat_bytes;
  logic [31:0] stat_underflows;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         first_cyc = -1;
  int         last_cyc = -1;
  int         bytes_since = 0;
  int         uf_since = 0;
  bit         stop_rnd = 1'b0;
  logic [7:0] sb[$];

  adc_sample_packer #(
    .pSAMPLE_BITS (12),
    .pCNT_BITS    (32)
  ) dut (
    .clk_usb         (clk),
    .reset_n         (reset_n),
    .cfg_low_res     (cfg_low_res),
    .clear           (clear),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_last         (in_last),
    .in_ready        (in_ready),
    .out_byte        (out_byte),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .underflow       (underflow),
    .stat_bytes      (stat_bytes),
    .stat_underflows (stat_underflows)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor: pops the scoreboard on every consumed byte
  always @(negedge clk) begin
    if (reset_n) begin
      if (underflow) uf_since++;
      if (out_valid && out_ready) begin
        bytes_since++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL byte_unexpected: got %02h, scoreboard empty", out_byte);
        end else begin
          logic [7:0] e;
          e = sb.pop_front();
          if (out_byte !== e) begin
            fails++;
            $display("FAIL byte_stream: got %02h expected %02h (cycle %0d)", out_byte, e, cyc);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_stats();
`ifdef ADC_PACKER_STATS_EN
    check("stat_bytes", stat_bytes, bytes_since);
    check("stat_underflows", stat_underflows, uf_since);
`else
    check("stat_bytes_tied", stat_bytes, 32'd0);
    check("stat_underflows_tied", stat_underflows, 32'd0);
`endif
  endtask

  task automatic send(input logic [11:0] d, input logic last);
    bit ok;
    ok = 1'b0;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready never rose for sample %03h", d);
    end
  endtask

  // Raise out_ready one cycle after the first byte appears
  task automatic start_reader();
    fork
      begin
        for (int n = 0; n < 200; n++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join_none
  endtask

  task automatic drain(input bit rnd);
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d bytes still expected", sb.size());
      sb.delete();
    end
    if (rnd) begin
      stop_rnd = 1'b1;
      @(posedge clk); #2;
    end
    out_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic zero_counts();
    bytes_since = 0;
    uf_since    = 0;
  endtask

  initial begin
    logic [11:0] a, b;
    int u0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_byte", out_byte, 8'h00);
    check("rst_underflow", underflow, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check_stats();
    @(posedge clk); #1;

    // 12-bit ramp 0..5
    cfg_low_res = 1'b0;
    first_cyc = -1;
    u0 = uf_since;
    foreach (sb[i]) ;
    sb.push_back(8'h00); sb.push_back(8'h00); sb.push_back(8'h01);
    sb.push_back(8'h00); sb.push_back(8'h20); sb.push_back(8'h03);
    sb.push_back(8'h00); sb.push_back(8'h40); sb.push_back(8'h05);
    start_reader();
    for (int i = 0; i < 6; i++) send(12'(i), 1'b0);
    drain(1'b0);
    check("ramp12_span", last_cyc - first_cyc, 32'd8);
    check("ramp12_no_underflow", uf_since - u0, 32'd0);
    check_stats();

    // Low-res ramp: 256 bytes, one per clock
    cfg_low_res = 1'b1;
    first_cyc = -1;
    u0 = uf_since;
    for (int i = 0; i < 256; i++) sb.push_back(8'(i));
    start_reader();
    for (int i = 0; i < 256; i++) send({8'(i), 4'h0}, 1'b0);
    drain(1'b0);
    check("lowres_span", last_cyc - first_cyc, 32'd255);
    check("lowres_no_underflow", uf_since - u0, 32'd0);

    // Odd tail with in_last
    cfg_low_res = 1'b0;
    sb.push_back(8'hAB); sb.push_back(8'hCD); sb.push_back(8'hEF);
    sb.push_back(8'h12); sb.push_back(8'h30);
    start_reader();
    send(12'hABC, 1'b0);
    send(12'hDEF, 1'b0);
    send(12'h123, 1'b1);
    drain(1'b0);
    @(negedge clk);
    check("tail_idle_in_ready", in_ready, 1'b1);
    check("tail_idle_out_valid", out_valid, 1'b0);
    check_stats();
    @(posedge clk); #1;

    // 90-sample ramp with random read and FIFO stalls
    for (int i = 0; i < 45; i++) begin
      a = 12'(2 * i);
      b = 12'(2 * i + 1);
      sb.push_back(a[11:4]);
      sb.push_back({a[3:0], b[11:8]});
      sb.push_back(b[7:0]);
    end
    stop_rnd = 1'b0;
    fork
      begin
        forever begin
          @(posedge clk); #1;
          if (stop_rnd) break;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 90; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      send(12'(i), 1'b0);
    end
    drain(1'b1);
    check_stats();

    // Read while empty
    u0 = uf_since;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("uflow_pulse", underflow, 1'b1);
    check("uflow_byte_held", out_byte, 8'h59);
    check("uflow_out_valid", out_valid, 1'b0);
    @(negedge clk);
    check("uflow_pulse_end", underflow, 1'b0);
    #1 check("uflow_count", uf_since - u0, 32'd1);

    // Clear, then a single underflow counted from zero
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    zero_counts();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("uflow_after_clear_byte", out_byte, 8'h00);
    #1 check("uflow_after_clear_count", uf_since, 32'd1);
    check_stats();
    @(posedge clk); #1;

    // Clear in PH_B discards the residue
    send(12'h789, 1'b0);
    @(negedge clk);
    check("phb_out_valid", out_valid, 1'b1);
    check("phb_out_byte", out_byte, 8'h78);
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    zero_counts();
    @(negedge clk);
    check("clear_out_valid", out_valid, 1'b0);
    check("clear_out_byte", out_byte, 8'h00);
    check("clear_in_ready", in_ready, 1'b1);
    check_stats();
    @(posedge clk); #1;
    sb.push_back(8'h45); sb.push_back(8'h60);
    start_reader();
    send(12'h456, 1'b1);
    drain(1'b0);

    // Reset in PH_B discards the residue
    send(12'hA5A, 1'b0);
    #1 reset_n = 1'b0;
    zero_counts();
    @(negedge clk);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_byte", out_byte, 8'h00);
    @(posedge clk); #1;
    reset_n = 1'b1;
    sb.push_back(8'h45); sb.push_back(8'h60);
    start_reader();
    send(12'h456, 1'b1);
    drain(1'b0);
    check_stats();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

endmodule
